// File: rtl/fp_invsqrt_arb.sv
// fp_invsqrt_arb: round-robin sharing of one fixed-latency bf16 1/sqrt pipe among NUM_REQ lanes
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   en                   allow new grants; in-flight ops always drain
//   req_vld/req_x/req_rdy per-lane request handshake (req_rdy is a one-hot grant)
//   pipe_x/pipe_x_vld    registered operand to the pipe
//   pipe_y/pipe_y_vld    result from the pipe
//   rsp_y/rsp_vld        registered result and one-hot owner pulse
//   busy                 some lane has an op outstanding
//   err                  sticky: pipe result valid disagreed with the tag line
module fp_invsqrt_arb #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int LATENCY = 17
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic [NUM_REQ-1:0]     req_vld,
    input  logic [16*NUM_REQ-1:0]  req_x,
    output logic [NUM_REQ-1:0]     req_rdy,
    output logic [15:0]            pipe_x,
    output logic                   pipe_x_vld,
    input  logic [15:0]            pipe_y,
    input  logic                   pipe_y_vld,
    output logic [15:0]            rsp_y,
    output logic [NUM_REQ-1:0]     rsp_vld,
    output logic                   busy,
    output logic                   err
);
    logic [ID_W-1:0]    ptr, gnt_id, x_id, idx;
    logic               gnt;
    logic [NUM_REQ-1:0] outst, elig, ret_mask;
    logic [LATENCY-1:0] tag_vld;
    logic [ID_W-1:0]    tag_id [LATENCY];
    logic               ret;

    // rst_n gating keeps req_rdy low while reset is held
    assign elig = req_vld & ~outst & {NUM_REQ{en & rst_n}};

    always_comb begin
        req_rdy = '0;
        gnt_id  = '0;
        gnt     = 1'b0;
        idx     = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = ID_W'((int'(ptr) + k) % NUM_REQ);
            if (!gnt && elig[idx]) begin
                gnt          = 1'b1;
                gnt_id       = idx;
                req_rdy[idx] = 1'b1;
            end
        end
    end

    // The tag line is fed from the registered operand stage, so its last entry
    // lines up with pipe_y_vld for the op that pipe_x_vld launched.
    assign ret      = tag_vld[LATENCY-1] & pipe_y_vld;
    assign ret_mask = ret ? NUM_REQ'(1) << tag_id[LATENCY-1] : '0;
    assign busy     = |outst;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr        <= ID_W'(NUM_REQ - 1);
            outst      <= '0;
            pipe_x     <= '0;
            pipe_x_vld <= 1'b0;
            x_id       <= '0;
            tag_vld    <= '0;
            for (int k = 0; k < LATENCY; k++) tag_id[k] <= '0;
            rsp_y      <= '0;
            rsp_vld    <= '0;
            err        <= 1'b0;
        end else begin
            if (gnt) begin
                ptr    <= gnt_id;
                pipe_x <= req_x[16*gnt_id +: 16];
            end
            pipe_x_vld <= gnt;
            x_id       <= gnt ? gnt_id : '0;
            tag_vld    <= {tag_vld[LATENCY-2:0], pipe_x_vld};
            tag_id[0]  <= x_id;
            for (int k = 1; k < LATENCY; k++) tag_id[k] <= tag_id[k-1];
            outst      <= (outst & ~ret_mask) | req_rdy;
            rsp_vld    <= ret_mask;
            if (ret) rsp_y <= pipe_y;
            if (tag_vld[LATENCY-1] != pipe_y_vld) err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_fp_invsqrt_arb.sv
// tb_fp_invsqrt_arb: directed bench for fp_invsqrt_arb with a behavioural fixed-latency pipe
module tb_fp_invsqrt_arb;
    localparam int N   = 4;
    localparam int LAT = 17;

    logic          clk = 1'b0;
    logic          rst_n, en, spur;
    logic [N-1:0]  req_vld, req_rdy, rsp_vld;
    logic [16*N-1:0] req_x;
    logic [15:0]   pipe_x, pipe_y, rsp_y;
    logic          pipe_x_vld, pipe_y_vld, busy, err;
    int            cyc = 0;
    int            n_chk = 0;
    int            n_fail = 0;
    int            g;
    logic [N-1:0]  seen;

    fp_invsqrt_arb #(.NUM_REQ(N), .ID_W(2), .LATENCY(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .req_vld(req_vld), .req_x(req_x),
        .req_rdy(req_rdy), .pipe_x(pipe_x), .pipe_x_vld(pipe_x_vld),
        .pipe_y(pipe_y), .pipe_y_vld(pipe_y_vld), .rsp_y(rsp_y),
        .rsp_vld(rsp_vld), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // stand-in pipe: 4.0 -> 0.5, anything else inverted bitwise so data is traceable
    function automatic logic [15:0] f(input logic [15:0] x);
        return (x == 16'h4080) ? 16'h3F00 : ~x;
    endfunction

    logic [15:0]    m_d [LAT];
    logic [LAT-1:0] m_v;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_v <= '0;
        else begin
            m_v    <= {m_v[LAT-2:0], pipe_x_vld};
            m_d[0] <= f(pipe_x);
            for (int k = 1; k < LAT; k++) m_d[k] <= m_d[k-1];
        end
    end
    assign pipe_y     = m_d[LAT-1];
    assign pipe_y_vld = m_v[LAT-1] | spur;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rsp();
        int n = 0;
        while (rsp_vld == '0 && n < 60) begin
            step();
            n++;
        end
        check("rsp_arrived", 32'(rsp_vld != '0), 1);
    endtask

    task automatic do_reset();
        req_vld = '0;
        en      = 1'b1;
        rst_n   = 1'b0;
        step();
        rst_n   = 1'b1;
        step();
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1; req_vld = '0; req_x = '0; spur = 1'b0;
        step(); step();
        check("rst_rdy", 32'(req_rdy), 0);
        check("rst_xvld", 32'(pipe_x_vld), 0);
        check("rst_rsp", 32'(rsp_vld), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_err", 32'(err), 0);
        rst_n = 1'b1;
        step();

        // single lane, 4.0 -> 0.5
        req_x[15:0] = 16'h4080;
        req_vld = 4'b0001;
        #1;
        check("t1_rdy", 32'(req_rdy), 32'b0001);
        g = cyc;
        step();
        req_vld = '0;
        check("t1_xvld", 32'(pipe_x_vld), 1);
        check("t1_x", 32'(pipe_x), 32'h4080);
        check("t1_busy", 32'(busy), 1);
        wait_rsp();
        check("t1_lat", 32'(cyc - g), 19);
        check("t1_rsp", 32'(rsp_vld), 32'b0001);
        check("t1_y", 32'(rsp_y), 32'h3F00);
        step();
        check("t1_rsp_end", 32'(rsp_vld), 0);
        check("t1_idle", 32'(busy), 0);

        // all lanes requesting continuously
        do_reset();
        req_x = {16'h4000, 16'h3000, 16'h2000, 16'h1000};
        req_vld = 4'b1111;
        #1;
        g = cyc;
        for (int i = 0; i < 4; i++) begin
            check("t2_gnt", 32'(req_rdy), 32'(4'b0001 << i));
            step();
        end
        check("t2_none", 32'(req_rdy), 0);
        wait_rsp();
        check("t2_lat", 32'(cyc - g), 19);
        for (int i = 0; i < 4; i++) begin
            logic [15:0] ey [4];
            ey = '{16'hEFFF, 16'hDFFF, 16'hCFFF, 16'hBFFF};
            check("t2_rsp", 32'(rsp_vld), 32'(4'b0001 << i));
            check("t2_y", 32'(rsp_y), 32'(ey[i]));
            if (i == 0) begin
                check("t2_regrant", 32'(req_rdy), 32'b0001);
                req_vld = '0;
            end
            step();
        end

        // lanes 1 and 3 with ptr parked at 1
        do_reset();
        req_x = {16'h5678, 16'h0000, 16'h1234, 16'h0000};
        req_vld = 4'b0010;
        #1;
        check("t3_pre", 32'(req_rdy), 32'b0010);
        step();
        req_vld = '0;
        wait_rsp();
        check("t3_pre_rsp", 32'(rsp_vld), 32'b0010);
        step();
        req_vld = 4'b1010;
        #1;
        check("t3_g3", 32'(req_rdy), 32'b1000);
        step();
        check("t3_g1", 32'(req_rdy), 32'b0010);
        step();
        req_vld = '0;
        wait_rsp();
        check("t3_rsp3", 32'(rsp_vld), 32'b1000);
        check("t3_y3", 32'(rsp_y), 32'hA987);
        step();
        check("t3_rsp1", 32'(rsp_vld), 32'b0010);
        check("t3_y1", 32'(rsp_y), 32'hEDCB);

        // en dropped after two grants
        do_reset();
        req_x = {16'h4000, 16'h3000, 16'h2000, 16'h1000};
        req_vld = 4'b1111;
        #1;
        check("t4_g0", 32'(req_rdy), 32'b0001);
        step();
        check("t4_g1", 32'(req_rdy), 32'b0010);
        step();
        en = 1'b0;
        #1;
        check("t4_stop", 32'(req_rdy), 0);
        wait_rsp();
        check("t4_rsp0", 32'(rsp_vld), 32'b0001);
        check("t4_busy_mid", 32'(busy), 1);
        check("t4_no_rdy", 32'(req_rdy), 0);
        step();
        check("t4_rsp1", 32'(rsp_vld), 32'b0010);
        check("t4_y1", 32'(rsp_y), 32'hDFFF);
        check("t4_busy_end", 32'(busy), 0);
        req_vld = '0;
        en = 1'b1;

        // spurious result valid on an empty tag slot
        do_reset();
        spur = 1'b1;
        step();
        spur = 1'b0;
        check("t5_err", 32'(err), 1);
        check("t5_no_rsp", 32'(rsp_vld), 0);
        step(); step();
        check("t5_sticky", 32'(err), 1);

        // reset with three ops in flight
        do_reset();
        check("t6_err_clr", 32'(err), 0);
        req_x = {16'h4000, 16'h3000, 16'h2000, 16'h1000};
        req_vld = 4'b0111;
        step(); step(); step();
        req_vld = '0;
        check("t6_busy", 32'(busy), 1);
        repeat (5) step();
        rst_n = 1'b0;
        #1;
        check("t6_xvld", 32'(pipe_x_vld), 0);
        check("t6_x", 32'(pipe_x), 0);
        check("t6_busy0", 32'(busy), 0);
        check("t6_rsp0", 32'(rsp_vld), 0);
        step();
        rst_n = 1'b1;
        seen = '0;
        repeat (40) begin
            step();
            seen |= rsp_vld;
        end
        check("t6_no_rsp", 32'(seen), 0);
        check("t6_no_err", 32'(err), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
